mem_wr_stage: RTL and testbench
===============================

# mem_wr_stage

Parametrised MEM/WB pipeline stage for the pipelined MIPS core: registers the memory-stage bundle, decodes the held instruction, and drives the register-file write port. It extends the write-back decoder with stall/flush handling, destination-register selection, sub-word load extraction and a retired-instruction counter. It sits between data memory and the register file, and its outputs also feed the forwarding unit.

## Interface
- DATA_W, 32 — datapath width (≥32); load/ALU/link values and wb_data.
- CNT_W, 32 — retired-instruction counter width.
- HAS_SUBWORD, 1 — 1: lb/lbu/lh/lhu extract and extend; 0: all loads return the full word.

- clk  in  1  — single clock, rising edge.
- rst  in  1  — asynchronous, active-high reset.
- in_valid  in  1  — MEM-stage slot holds a real instruction.
- in_instr  in  32  — instruction word (op = [31:26], rt = [20:16], rd = [15:11], funct = [5:0]).
- in_alu  in  DATA_W  — ALU result / memory address.
- in_mem  in  DATA_W  — word read from data memory.
- in_link  in  DATA_W  — link value for jal/jalr.
- stall  in  1  — hold the stage contents.
- flush  in  1  — insert a bubble.
- wb_en  out  1  — register-file write enable.
- wb_addr  out  5  — destination register.
- wb_data  out  DATA_W  — write-back value.
- wb_valid  out  1  — stage holds a valid instruction.
- retired  out  CNT_W  — count of instructions that have left the stage.

## Operation
- State: valid_q, instr_q, alu_q, mem_q, link_q, cnt_q.
- Capture on each rising edge, in priority order:
  - flush → valid_q ← 0; other registers don't-care. Flush beats stall.
  - else stall → all registers hold.
  - else → valid_q ← in_valid and data registers ← inputs.
- Decode of instr_q, with destination:
  - R-type (op 000000), funct ≠ 001000 → rd. jr (funct 001000) does not write.
  - I-type ALU (op 001000–001111) → rt.
  - Loads lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101 → rt.
  - jal 000011 → 31.
  - jalr (op 0, funct 001001) → rd.
  - Stores (101000, 101001, 101011), branches (000001, 000100–000111), j 000010 and all unlisted opcodes → no write.
- Write-back source:
  - Loads → extracted load value.
  - jal/jalr → link_q.
  - Otherwise → alu_q.
- Sub-word extraction (HAS_SUBWORD=1, little-endian, a = alu_q[1:0]):
  - byte = mem_q[8a+7:8a].
  - half = mem_q[16·a[1]+15 : 16·a[1]]; a[0] is ignored.
  - lb/lh sign-extend to DATA_W; lbu/lhu zero-extend.
  - lw: mem_q[31:0], zero-extended to DATA_W if DATA_W > 32.
- wb_en = valid_q & writes & (dest ≠ 0). Writes to $0 are suppressed.
- wb_addr and wb_data are forced to 0 when wb_en = 0.
- wb_valid = valid_q.
- Counter: cnt_q increments at an edge when valid_q = 1 and stall = 0, regardless of flush. It wraps from 2^CNT_W−1 to 0.

## Timing
- Latency: inputs captured at edge N appear on wb_* after edge N, combinationally from the registers, for the whole cycle N→N+1.
- During stall, wb_en stays asserted with identical addr/data; rewriting the same value is harmless.
- The counter is not advanced while stalled.
- Reset (asynchronous, immediate, and also mid-stall/mid-flush): valid_q=0, all data registers 0, cnt_q=0.
  - Outputs in reset: wb_en=0, wb_addr=0, wb_data=0, wb_valid=0, retired=0.
- After rst deasserts, the first capture happens at the next rising edge.
- There is no combinational path from stall/flush to wb_*; only the register state drives outputs.

## Test plan
- Issue addi $5 (op 001000, rt=5) with in_alu=0x0000_0042, in_valid=1 → next cycle wb_en=1, wb_addr=5, wb_data=0x42; retired goes 0→1 on the following edge.
- Issue lb with in_mem=0x80FF_7F01 and in_alu low bits 01, then 11; repeat with lbu, lh (a=10), lhu (a=10):
  - lb a=01 → 0x7F; lb a=11 → 0xFFFF_FF80.
  - lbu a=11 → 0x80.
  - lh a=10 → 0xFFFF_80FF; lhu a=10 → 0x80FF.
  - With HAS_SUBWORD=0, all four return 0x80FF_7F01.
- Issue jal with in_link=0x0040_0008 → wb_addr=31, wb_data=0x0040_0008. Issue jalr rd=0 → wb_en=0. Issue sw, beq, j, jr → wb_en=0, wb_valid=1.
- Hold an addu in the stage with stall=1 for 3 cycles while changing the inputs → outputs unchanged and retired unchanged. Then stall=flush=1 → bubble (wb_valid=0), and retired increments only if stall=0 on that edge.
- With CNT_W=4, retire 17 instructions back-to-back → retired reads 15, then 0, then 1.
- Assert rst mid-stream with wb_en=1 → all outputs go to 0 immediately, before any clock edge. After release, a new instruction captured on the first edge appears normally.

Source files
------------

// File: rtl/mem_wr_stage.sv
// MEM/WB pipeline stage: holds the memory-stage bundle, decodes the held
// instruction and drives the register-file write port plus a retire counter.
module mem_wr_stage #(
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 32,
  parameter int HAS_SUBWORD = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mem,
  input  logic [DATA_W-1:0] in_link,
  input  logic              stall,
  input  logic              flush,
  output logic              wb_en,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_valid,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] mem_q, mem_d;
  logic [DATA_W-1:0] link_q, link_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [5:0]        op_s;
  logic [5:0]        funct_s;
  logic              writes_s;
  logic [4:0]        dest_s;
  logic              is_load_s;
  logic              is_link_s;
  logic [7:0]        byte_s;
  logic [15:0]       half_s;
  logic [DATA_W-1:0] word_s;
  logic [DATA_W-1:0] load_s;
  logic [DATA_W-1:0] data_s;
  logic              en_s;
  logic              unused_s;

  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic sgn);
    logic [DATA_W-1:0] r;
    r      = {DATA_W{sgn & b[7]}};
    r[7:0] = b;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic sgn);
    logic [DATA_W-1:0] r;
    r       = {DATA_W{sgn & h[15]}};
    r[15:0] = h;
    return r;
  endfunction

  // Next state: flush beats stall; the counter looks only at valid_q and stall.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    alu_d   = alu_q;
    mem_d   = mem_q;
    link_d  = link_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (stall) begin
      valid_d = valid_q;
    end else begin
      valid_d = in_valid;
      instr_d = in_instr;
      alu_d   = in_alu;
      mem_d   = in_mem;
      link_d  = in_link;
    end
    if (valid_q && !stall) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      alu_q   <= '0;
      mem_q   <= '0;
      link_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      alu_q   <= alu_d;
      mem_q   <= mem_d;
      link_q  <= link_d;
      cnt_q   <= cnt_d;
    end
  end

  assign op_s     = instr_q[31:26];
  assign funct_s  = instr_q[5:0];
  assign unused_s = ^{instr_q[25:21], instr_q[10:6]};

  // Destination and write-back source decode of the held instruction.
  always_comb begin
    writes_s  = 1'b0;
    dest_s    = 5'd0;
    is_load_s = 1'b0;
    is_link_s = 1'b0;
    case (op_s)
      OP_RTYPE: begin
        if (funct_s == FN_JR) begin
          writes_s = 1'b0;
        end else begin
          writes_s  = 1'b1;
          dest_s    = instr_q[15:11];
          is_link_s = (funct_s == FN_JALR);
        end
      end
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        writes_s = 1'b1;
        dest_s   = instr_q[20:16];
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        writes_s  = 1'b1;
        dest_s    = instr_q[20:16];
        is_load_s = 1'b1;
      end
      OP_JAL: begin
        writes_s  = 1'b1;
        dest_s    = 5'd31;
        is_link_s = 1'b1;
      end
      default: begin
        writes_s = 1'b0;
      end
    endcase
  end

  // Little-endian sub-word selection; halfword ignores address bit 0.
  always_comb begin
    byte_s      = mem_q[{alu_q[1:0], 3'b000} +: 8];
    half_s      = mem_q[{alu_q[1], 4'b0000} +: 16];
    word_s      = '0;
    word_s[31:0] = mem_q[31:0];
    load_s      = word_s;
    if (HAS_SUBWORD != 32'sd0) begin
      case (op_s)
        OP_LB:   load_s = ext_byte(byte_s, 1'b1);
        OP_LBU:  load_s = ext_byte(byte_s, 1'b0);
        OP_LH:   load_s = ext_half(half_s, 1'b1);
        OP_LHU:  load_s = ext_half(half_s, 1'b0);
        default: load_s = word_s;
      endcase
    end else begin
      load_s = word_s;
    end
  end

  // Write-back mux and port gating; $0 writes are suppressed.
  always_comb begin
    if (is_load_s) begin
      data_s = load_s;
    end else if (is_link_s) begin
      data_s = link_q;
    end else begin
      data_s = alu_q;
    end
    en_s = valid_q & writes_s & (dest_s != 5'd0);
    if (en_s) begin
      wb_addr = dest_s;
      wb_data = data_s;
    end else begin
      wb_addr = 5'd0;
      wb_data = '0;
    end
  end

  assign wb_en    = en_s;
  assign wb_valid = valid_q;
  assign retired  = cnt_q;

endmodule

// File: tb/tb_mem_wr_stage.sv
// Scoreboard bench for mem_wr_stage: a default instance and a HAS_SUBWORD=0,
// CNT_W=4 instance share one stimulus stream.
module tb_mem_wr_stage;

  typedef struct packed {
    logic        v;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] data_ns;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr, in_alu, in_mem, in_link;
  logic        stall, flush;
  logic        wb_en, wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, retired;
  logic        wb_en2, wb_valid2;
  logic [4:0]  wb_addr2;
  logic [31:0] wb_data2;
  logic [3:0]  retired2;

  int          total;
  int          bad;
  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] exp_cnt;

  mem_wr_stage #(.DATA_W(32), .CNT_W(32), .HAS_SUBWORD(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
    .in_alu(in_alu), .in_mem(in_mem), .in_link(in_link),
    .stall(stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_valid(wb_valid), .retired(retired)
  );

  mem_wr_stage #(.DATA_W(32), .CNT_W(4), .HAS_SUBWORD(0)) dut_ns (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
    .in_alu(in_alu), .in_mem(in_mem), .in_link(in_link),
    .stall(stall), .flush(flush), .wb_en(wb_en2), .wb_addr(wb_addr2),
    .wb_data(wb_data2), .wb_valid(wb_valid2), .retired(retired2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
    return {op, 5'd3, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, 5'd4, 5'd2, rd, 5'd0, fn};
  endfunction

  // Reference model of what the stage should present for one captured slot.
  function automatic exp_t model(input logic v, input logic [31:0] ins, input logic [31:0] alu,
                                 input logic [31:0] mem, input logic [31:0] link);
    exp_t        e;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        wr;
    logic [4:0]  dst;
    logic [31:0] res, res_ns;
    logic [7:0]  b;
    logic [15:0] h;
    int          sh;
    op = ins[31:26];
    fn = ins[5:0];
    wr = 1'b0;
    dst = 5'd0;
    res = alu;
    res_ns = alu;
    sh = 8 * int'(alu[1:0]);
    b = 8'(mem >> sh);
    h = alu[1] ? mem[31:16] : mem[15:0];
    if (op == 6'b000000 && fn != 6'b001000) begin
      wr = 1'b1;
      dst = ins[15:11];
      if (fn == 6'b001001) begin
        res = link;
        res_ns = link;
      end
    end else if (op[5:3] == 3'b001) begin
      wr = 1'b1;
      dst = ins[20:16];
    end else if (op == 6'b000011) begin
      wr = 1'b1;
      dst = 5'd31;
      res = link;
      res_ns = link;
    end else if (op inside {6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101}) begin
      wr = 1'b1;
      dst = ins[20:16];
      res_ns = mem;
      case (op)
        6'b100000: res = {{24{b[7]}}, b};
        6'b100100: res = {24'h0, b};
        6'b100001: res = {{16{h[15]}}, h};
        6'b100101: res = {16'h0, h};
        default:   res = mem;
      endcase
    end
    e.v = v;
    e.en = v && wr && (dst != 5'd0);
    e.addr = e.en ? dst : 5'd0;
    e.data = e.en ? res : 32'd0;
    e.data_ns = e.en ? res_ns : 32'd0;
    return e;
  endfunction

  // One cycle: drive at negedge, advance model at posedge, compare at posedge+1.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] alu,
                      input logic [31:0] mem, input logic [31:0] link,
                      input logic st, input logic fl);
    in_valid = v;
    in_instr = ins;
    in_alu = alu;
    in_mem = mem;
    in_link = link;
    stall = st;
    flush = fl;
    if (!st && !fl) sb.push_back(model(v, ins, alu, mem, link));
    @(posedge clk);
    if (cur.v && !st) exp_cnt = exp_cnt + 32'd1;
    if (fl) begin
      cur = '0;
    end else if (!st) begin
      if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else cur = sb.pop_front();
    end
    #1;
    chk("wb_valid", {31'd0, wb_valid}, {31'd0, cur.v});
    chk("wb_en", {31'd0, wb_en}, {31'd0, cur.en});
    chk("wb_addr", {27'd0, wb_addr}, {27'd0, cur.addr});
    chk("wb_data", wb_data, cur.data);
    chk("retired", retired, exp_cnt);
    chk("ns_wb_en", {31'd0, wb_en2}, {31'd0, cur.en});
    chk("ns_wb_data", wb_data2, cur.data_ns);
    chk("ns_retired", {28'd0, retired2}, {28'd0, exp_cnt[3:0]});
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_en"}, {31'd0, wb_en}, 32'd0);
    chk({tag, "_addr"}, {27'd0, wb_addr}, 32'd0);
    chk({tag, "_data"}, wb_data, 32'd0);
    chk({tag, "_valid"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, "_ret"}, retired, 32'd0);
    chk({tag, "_ns_ret"}, {28'd0, retired2}, 32'd0);
  endtask

  logic [31:0] m;
  logic [5:0]  ops [12];

  initial begin
    total = 0;
    bad = 0;
    exp_cnt = 32'd0;
    cur = '0;
    m = 32'h80FF_7F01;
    ops = '{6'b000000, 6'b001000, 6'b001101, 6'b100000, 6'b100001, 6'b100011,
            6'b100100, 6'b100101, 6'b000011, 6'b101011, 6'b000100, 6'b000010};
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = 32'd0;
    in_alu = 32'd0;
    in_mem = 32'd0;
    in_link = 32'd0;
    stall = 1'b0;
    flush = 1'b0;
    #3;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    step(1'b1, itype(6'b001000, 5'd5, 16'h0042), 32'h0000_0042, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    step(1'b1, itype(6'b100000, 5'd6, 16'h1), 32'h0000_1001, m, 32'd0, 1'b0, 1'b0);
    step(1'b1, itype(6'b100000, 5'd6, 16'h3), 32'h0000_1003, m, 32'd0, 1'b0, 1'b0);
    step(1'b1, itype(6'b100100, 5'd6, 16'h3), 32'h0000_1003, m, 32'd0, 1'b0, 1'b0);
    step(1'b1, itype(6'b100001, 5'd6, 16'h2), 32'h0000_1002, m, 32'd0, 1'b0, 1'b0);
    step(1'b1, itype(6'b100101, 5'd6, 16'h2), 32'h0000_1002, m, 32'd0, 1'b0, 1'b0);
    step(1'b1, itype(6'b100011, 5'd8, 16'h0), 32'h0000_2000, m, 32'd0, 1'b0, 1'b0);

    step(1'b1, {6'b000011, 26'h0100002}, 32'h99, 32'd0, 32'h0040_0008, 1'b0, 1'b0);
    step(1'b1, rtype(5'd0, 6'b001001), 32'h55, 32'd0, 32'h0040_0010, 1'b0, 1'b0);
    step(1'b1, rtype(5'd7, 6'b001001), 32'h55, 32'd0, 32'h0040_0020, 1'b0, 1'b0);
    step(1'b1, itype(6'b101011, 5'd3, 16'h4), 32'h77, m, 32'd0, 1'b0, 1'b0);
    step(1'b1, itype(6'b000100, 5'd3, 16'h4), 32'h77, m, 32'd0, 1'b0, 1'b0);
    step(1'b1, {6'b000010, 26'h0000040}, 32'h77, m, 32'd0, 1'b0, 1'b0);
    step(1'b1, rtype(5'd0, 6'b001000), 32'h77, m, 32'd0, 1'b0, 1'b0);
    step(1'b1, itype(6'b001000, 5'd0, 16'h9), 32'h9, 32'd0, 32'd0, 1'b0, 1'b0);

    // Held addu under stall while inputs change, then stall+flush bubble.
    step(1'b1, rtype(5'd9, 6'b100001), 32'h0000_1234, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, itype(6'b001000, 5'd12, 16'hdead), 32'hDEAD_0000 + i, m, 32'h1, 1'b1, 1'b0);
    step(1'b1, rtype(5'd10, 6'b100001), 32'h1, 32'd0, 32'd0, 1'b1, 1'b1);
    step(1'b1, rtype(5'd11, 6'b100001), 32'h2, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, rtype(5'd11, 6'b100001), 32'h3, 32'd0, 32'd0, 1'b0, 1'b1);

    for (int i = 0; i < 17; i++)
      step(1'b1, rtype(5'(i + 1), 6'b100001), 32'h100 + i, 32'd0, 32'd0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ins;
      ins = $urandom();
      ins[31:26] = ops[$urandom_range(0, 11)];
      step(1'($urandom_range(0, 3) != 0), ins, $urandom(), $urandom(), $urandom(),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0));
    end

    // Asynchronous reset with a live write on the port.
    step(1'b1, itype(6'b001000, 5'd5, 16'h0042), 32'h0000_0042, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("pre_rst_en", {31'd0, wb_en}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    sb.delete();
    cur = '0;
    exp_cnt = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, itype(6'b001101, 5'd13, 16'h00AB), 32'h0000_00AB, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
